// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one result bit per cycle through a single
// shared WIDTH+1-bit adder. Busy covers the launch cycle plus WIDTH compute
// cycles; Done pulses for one cycle when Result1/Result2 update.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, COMPUTE} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div;       // only op bit needed after capture; signedness lives in the neg flags
    logic               r_dz;        // divisor was zero
    logic               r_neg_res;   // signed op with differing operand signs
    logic               r_neg_rem;   // signed op with negative dividend
    logic [WIDTH-1:0]   r_m;         // multiplicand (mul) or divisor (div), magnitude
    logic [WIDTH-1:0]   r_op1;       // raw Operand1, returned on divide by zero
    logic [2*WIDTH-1:0] r_acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_res1;
    logic [WIDTH-1:0]   r_res2;
    logic               r_done;

    logic               w_signed;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_add_a;
    logic [WIDTH:0]     w_add_b;
    logic               w_add_ci;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_r1;
    logic [WIDTH-1:0]   w_r2;

    assign Busy    = ((r_state == IDLE) & Start) | (r_state == COMPUTE);
    assign Done    = r_done;
    assign Result1 = r_res1;
    assign Result2 = r_res2;

    // Magnitudes of the incoming operands (signed ops only)
    assign w_signed = ~MCycleOp[0];
    assign w_abs1   = (w_signed & Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    assign w_abs2   = (w_signed & Operand2[WIDTH-1]) ? -Operand2 : Operand2;

    // Shared adder operand select: divide subtracts the divisor, multiply adds the multiplicand
    always_comb begin
        w_div_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_add_a  = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        w_add_b  = r_acc[0] ? {1'b0, r_m} : '0;
        w_add_ci = 1'b0;
        if (r_div) begin
            w_add_a  = w_div_sh;
            w_add_b  = ~{1'b0, r_m};
            w_add_ci = 1'b1;
        end
    end

    assign w_sum = w_add_a + w_add_b + {{WIDTH{1'b0}}, w_add_ci};

    // One iteration: right-shift-accumulate for mul, restoring step for div
    always_comb begin
        w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        if (r_div) begin
            if (!w_sum[WIDTH])
                w_acc_nxt = {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_acc_nxt = {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the final iteration
    always_comb begin
        w_prod = r_neg_res ? -w_acc_nxt : w_acc_nxt;
        w_quo  = r_neg_res ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
        w_rem  = r_neg_rem ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
        w_r1   = w_prod[WIDTH-1:0];
        w_r2   = w_prod[2*WIDTH-1:WIDTH];
        if (r_div) begin
            w_r1 = r_dz ? '1 : w_quo;
            w_r2 = r_dz ? r_op1 : w_rem;
        end
    end

    // Control FSM with operand capture, iteration and result registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_dz      <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_m       <= '0;
            r_op1     <= '0;
            r_acc     <= '0;
            r_res1    <= '0;
            r_res2    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_div     <= MCycleOp[1];
                        r_op1     <= Operand1;
                        r_dz      <= (Operand2 == '0);
                        r_neg_res <= w_signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        r_neg_rem <= w_signed & Operand1[WIDTH-1];
                        r_cnt     <= '0;
                        if (MCycleOp[1]) begin
                            r_m   <= w_abs2;
                            r_acc <= {{WIDTH{1'b0}}, w_abs1};
                        end else begin
                            r_m   <= w_abs1;
                            r_acc <= {{WIDTH{1'b0}}, w_abs2};
                        end
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_res1  <= w_r1;
                        r_res2  <= w_r2;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: hand-computed products/quotients, latency,
// ignored re-start and asynchronous reset abort.
module tb_mcycle_unit;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;
    int busy_cyc;
    int done_cnt;
    int done_at;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch an op at a negedge and watch 36 cycles; optionally pulse a
    // second Start with different operands at cycle glitch.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int glitch);
        @(negedge CLK);
        MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
        busy_cyc = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 36; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                Start = 1'b0;
                if (c == glitch) begin
                    MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd3; Start = 1'b1;
                end
            end
            #1;
            if (Busy) busy_cyc++;
            if (Done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_r1",   Result1, 0);
        chk("reset_r2",   Result2, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        chk("umul_max_r1",   Result1, 32'h00000001);
        chk("umul_max_r2",   Result2, 32'hFFFFFFFE);
        chk("umul_busy_cyc", busy_cyc, 33);
        chk("umul_done_cnt", done_cnt, 1);
        chk("umul_done_at",  done_at, 33);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1);
        chk("smul_m3x7_r1", Result1, 32'hFFFFFFEB);
        chk("smul_m3x7_r2", Result2, 32'hFFFFFFFF);

        run_op(2'b00, 32'h80000000, 32'h80000000, -1);
        chk("smul_minsq_r1", Result1, 32'h00000000);
        chk("smul_minsq_r2", Result2, 32'h40000000);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1);
        chk("sdiv_m7d2_r1", Result1, 32'hFFFFFFFD);
        chk("sdiv_m7d2_r2", Result2, 32'hFFFFFFFF);

        run_op(2'b11, 32'd100, 32'd7, -1);
        chk("udiv_100d7_r1", Result1, 32'd14);
        chk("udiv_100d7_r2", Result2, 32'd2);
        chk("udiv_done_at",  done_at, 33);

        run_op(2'b11, 32'd100, 32'd0, -1);
        chk("udiv_zero_r1", Result1, 32'hFFFFFFFF);
        chk("udiv_zero_r2", Result2, 32'd100);
        chk("udiv_zero_busy", busy_cyc, 33);

        run_op(2'b10, 32'hFFFFFFFB, 32'd0, -1);
        chk("sdiv_zero_r1", Result1, 32'hFFFFFFFF);
        chk("sdiv_zero_r2", Result2, 32'hFFFFFFFB);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
        chk("sdiv_ovf_r1", Result1, 32'h80000000);
        chk("sdiv_ovf_r2", Result2, 32'h00000000);

        run_op(2'b01, 32'd6, 32'd7, 5);
        chk("restart_r1",       Result1, 32'd42);
        chk("restart_r2",       Result2, 32'd0);
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_busy",     busy_cyc, 33);

        // Abort a divide in its tenth cycle with a mid-cycle reset
        @(negedge CLK);
        MCycleOp = 2'b11; Operand1 = 32'd1000; Operand2 = 32'd9; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        #2;
        chk("abort_busy_before", Busy, 1);
        RESET = 1'b1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_r1",   Result1, 0);
        chk("abort_r2",   Result2, 0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op(2'b01, 32'd6, 32'd7, -1);
        chk("post_reset_r1",   Result1, 32'd42);
        chk("post_reset_r2",   Result2, 32'd0);
        chk("post_reset_done", done_at, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
